// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational MIPS-subset ALU: decodes one request at a time,
// holds operands for SETTLE_CYCLES, captures the result and offers it on a response port.
module alu_issue_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [15:0] imm,
    output logic [3:0]  alu_ctl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out,
    input  logic [1:0]  alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_branch,
    output logic        rsp_illegal,
    output logic [1:0]  state_dbg
);
    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // the sender holds its payload stable while valid is high and ready is low.

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        is_beq;
    logic        accept;
    logic        dec_legal;
    logic [3:0]  dec_ctl;
    logic [31:0] dec_b;
    logic        unused_zero;

    assign unused_zero = alu_zero[1];
    assign state_dbg   = state;
    assign accept      = req_valid && req_ready;

    always_comb begin
        dec_legal = 1'b1;
        dec_ctl   = CTL_ADD;
        dec_b     = rt_val;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20:   dec_ctl = CTL_ADD;
                    6'h22:   dec_ctl = CTL_SUB;
                    6'h24:   dec_ctl = CTL_AND;
                    6'h25:   dec_ctl = CTL_OR;
                    6'h2A:   dec_ctl = CTL_SLT;
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h08, 6'h23, 6'h2B: dec_b = {{16{imm[15]}}, imm};
            6'h0A: begin
                dec_ctl = CTL_SLT;
                dec_b   = {{16{imm[15]}}, imm};
            end
            6'h0C: begin
                dec_ctl = CTL_AND;
                dec_b   = {16'h0000, imm};
            end
            6'h0D: begin
                dec_ctl = CTL_OR;
                dec_b   = {16'h0000, imm};
            end
            6'h04:   dec_ctl = CTL_SUB;
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = dec_legal ? EXEC : RESP;
            end
            EXEC:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Illegal requests enter RESP with rsp_valid low; it rises one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ctl     <= 4'd0;
            alu_a       <= 32'd0;
            alu_b       <= 32'd0;
            cnt         <= 4'd0;
            is_beq      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_result  <= 32'd0;
            rsp_branch  <= 1'b0;
            rsp_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (dec_legal) begin
                            alu_ctl <= dec_ctl;
                            alu_a   <= rs_val;
                            alu_b   <= dec_b;
                            is_beq  <= (opcode == 6'h04);
                            cnt     <= SETTLE_LOAD;
                        end else begin
                            rsp_illegal <= 1'b1;
                            rsp_result  <= 32'd0;
                            rsp_branch  <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        rsp_result  <= alu_out;
                        rsp_branch  <= is_beq & alu_zero[0];
                        rsp_illegal <= 1'b0;
                        rsp_valid   <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (!rsp_valid)     rsp_valid <= 1'b1;
                    else if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
